// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 32:1 single-bit mux: walks an inclusive select range, streams the
// sampled bits over valid/ready and accumulates population count and first set-bit index.
module mux_scan_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [4:0]  first_sel,
  input  logic [4:0]  last_sel,
  input  logic        abort,
  output logic [31:0] mux_source,
  output logic [4:0]  mux_select,
  input  logic        mux_result,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        bit_out,
  output logic [4:0]  bit_index,
  output logic        bit_last,
  output logic        busy,
  output logic        done,
  output logic [5:0]  ones_count,
  output logic        found,
  output logic [4:0]  first_one_idx
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [4:0]  sel_q, sel_d;
  logic [4:0]  last_q, last_d;
  logic        up_q, up_d;
  logic        valid_q, valid_d;
  logic        bout_q, bout_d;
  logic [4:0]  bidx_q, bidx_d;
  logic        blast_q, blast_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  ones_q, ones_d;
  logic        found_q, found_d;
  logic [4:0]  first_q, first_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    sel_d   = sel_q;
    last_d  = last_q;
    up_d    = up_q;
    valid_d = valid_q;
    bout_d  = bout_q;
    bidx_d  = bidx_q;
    blast_d = blast_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    found_d = found_q;
    first_d = first_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          busy_d  = 1'b1;
          src_d   = data_in;
          sel_d   = first_sel;
          last_d  = last_sel;
          up_d    = (first_sel <= last_sel);
          ones_d  = '0;
          found_d = 1'b0;
          first_d = '0;
        end
      end
      StScan: begin
        if (abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          blast_d = 1'b0;
          ones_d  = '0;
          found_d = 1'b0;
          first_d = '0;
        end else if (valid_q && bit_ready && blast_q) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!(valid_q && blast_q) && (!valid_q || bit_ready)) begin
          // A valid last bit means the range is exhausted; only draining remains.
          valid_d = 1'b1;
          bout_d  = mux_result;
          bidx_d  = sel_q;
          blast_d = (sel_q == last_q);
          if (sel_q != last_q) begin
            sel_d = up_q ? sel_q + 5'd1 : sel_q - 5'd1;
          end
          if (mux_result) begin
            ones_d = ones_q + 6'd1;
            if (!found_q) begin
              found_d = 1'b1;
              first_d = sel_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      sel_q   <= '0;
      last_q  <= '0;
      up_q    <= 1'b0;
      valid_q <= 1'b0;
      bout_q  <= 1'b0;
      bidx_q  <= '0;
      blast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      up_q    <= up_d;
      valid_q <= valid_d;
      bout_q  <= bout_d;
      bidx_q  <= bidx_d;
      blast_q <= blast_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      found_q <= found_d;
      first_q <= first_d;
    end
  end

  assign mux_source    = src_q;
  assign mux_select    = sel_q;
  assign bit_valid     = valid_q;
  assign bit_out       = bout_q;
  assign bit_index     = bidx_q;
  assign bit_last      = blast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ones_count    = ones_q;
  assign found         = found_q;
  assign first_one_idx = first_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a queue-based model of the expected bit stream checked every cycle,
// plus directed scans with hand-computed literal expectations.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, bit_ready;
  logic [31:0] data_in;
  logic [4:0]  first_sel, last_sel;
  logic [31:0] mux_source;
  logic [4:0]  mux_select, bit_index, first_one_idx;
  logic        mux_result, bit_valid, bit_out, bit_last, busy, done, found;
  logic [5:0]  ones_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External combinational 32:1 mux.
  assign mux_result = mux_source[mux_select];

  mux_scan_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .first_sel    (first_sel),
    .last_sel     (last_sel),
    .abort        (abort),
    .mux_source   (mux_source),
    .mux_select   (mux_select),
    .mux_result   (mux_result),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .bit_out      (bit_out),
    .bit_index    (bit_index),
    .bit_last     (bit_last),
    .busy         (busy),
    .done         (done),
    .ones_count   (ones_count),
    .found        (found),
    .first_one_idx(first_one_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] idx;
    logic       lst;
  } exp_bit_t;

  exp_bit_t    exp_q[$];
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_valid = 1'b0;
  logic [31:0] exp_src = '0;
  logic [5:0]  exp_ones = '0;
  logic        exp_found = 1'b0;
  logic [4:0]  exp_first = '0, exp_sel = '0, m_k;
  logic        check_cnt = 1'b1, after_reset = 1'b1, sel_check = 1'b0;
  logic        was_last;

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("bit_valid", 32'(bit_valid), 32'(exp_valid));
    chk("mux_source", mux_source, exp_src);
    if (exp_valid && exp_q.size() > 0) begin
      chk("bit_out", 32'(bit_out), 32'(exp_q[0].v));
      chk("bit_index", 32'(bit_index), 32'(exp_q[0].idx));
      chk("bit_last", 32'(bit_last), 32'(exp_q[0].lst));
    end else if (exp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bit_stream: bit valid beyond expected range (t=%0t)", $time);
    end
    if (check_cnt) begin
      chk("ones_count", 32'(ones_count), 32'(exp_ones));
      chk("found", 32'(found), 32'(exp_found));
      chk("first_one_idx", 32'(first_one_idx), 32'(exp_first));
    end
    if (sel_check) chk("mux_select_start", 32'(mux_select), 32'(exp_sel));
    if (after_reset) begin
      chk("rst_mux_select", 32'(mux_select), 0);
      chk("rst_bit_out", 32'(bit_out), 0);
      chk("rst_bit_index", 32'(bit_index), 0);
      chk("rst_bit_last", 32'(bit_last), 0);
    end

    // Advance the model using the inputs sampled at the coming rising edge.
    after_reset = 1'b0;
    sel_check   = 1'b0;
    if (reset) begin
      exp_busy = 0; exp_done = 0; exp_valid = 0; exp_src = '0;
      exp_ones = '0; exp_found = 0; exp_first = '0;
      exp_q.delete();
      check_cnt = 1; after_reset = 1;
    end else if (exp_busy) begin
      if (abort) begin
        exp_busy = 0; exp_valid = 0;
        exp_ones = '0; exp_found = 0; exp_first = '0;
        exp_q.delete();
        check_cnt = 1;
      end else if (exp_valid && bit_ready && exp_q.size() > 0) begin
        was_last = exp_q[0].lst;
        void'(exp_q.pop_front());
        if (was_last) begin
          exp_busy = 0; exp_done = 1; exp_valid = 0; check_cnt = 1;
        end
      end else begin
        exp_valid = 1;
      end
    end else begin
      exp_done = 0;
      if (start) begin
        exp_busy = 1; exp_valid = 0; check_cnt = 0;
        exp_src = data_in; exp_sel = first_sel; sel_check = 1;
        exp_ones = '0; exp_found = 0; exp_first = '0;
        exp_q.delete();
        m_k = first_sel;
        forever begin
          exp_q.push_back('{v: data_in[m_k], idx: m_k, lst: (m_k == last_sel)});
          if (data_in[m_k]) begin
            if (!exp_found) exp_first = m_k;
            exp_found = 1;
            exp_ones  = exp_ones + 6'd1;
          end
          if (m_k == last_sel) break;
          m_k = (first_sel <= last_sel) ? m_k + 5'd1 : m_k - 5'd1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Tasks assume they are entered just after a rising edge.
  task automatic do_start(input logic [31:0] d, input logic [4:0] f, input logic [4:0] l);
    start = 1; data_in = d; first_sel = f; last_sel = l;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; return; end
    end
  endtask

  int         cyc, stalls, ndone;
  logic [7:0] got;
  int         pat[4] = '{1, 0, 0, 1};

  initial begin
    reset = 1; start = 0; abort = 0; bit_ready = 1;
    data_in = '0; first_sel = '0; last_sel = '0;
    step(2);
    reset = 0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ones", 32'(ones_count), 0);
    step(1);

    // Full ascending scan.
    do_start(32'h805C_9BD2, 5'd0, 5'd31);
    chk("asc_busy", 32'(busy), 1);
    chk("asc_sel0", 32'(mux_select), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      got[k] = bit_out;
    end
    chk("asc_first_byte", 32'(got), 32'h0000_00D2);
    wait_done(cyc);
    chk("asc_latency", cyc, 33 - 8);
    chk("asc_ones", 32'(ones_count), 14);
    chk("asc_found", 32'(found), 1);
    chk("asc_first", 32'(first_one_idx), 1);
    step(2);

    // Full descending scan.
    do_start(32'h805C_9BD2, 5'd31, 5'd0);
    step(1);
    chk("desc_bit0", 32'(bit_out), 1);
    chk("desc_idx0", 32'(bit_index), 31);
    wait_done(cyc);
    chk("desc_latency", cyc, 32);
    chk("desc_ones", 32'(ones_count), 14);
    chk("desc_first", 32'(first_one_idx), 31);

    // Single-bit scans.
    do_start(32'h805C_9BD2, 5'd5, 5'd5);
    wait_done(cyc);
    chk("one5_latency", cyc, 2);
    chk("one5_ones", 32'(ones_count), 0);
    chk("one5_found", 32'(found), 0);
    chk("one5_first", 32'(first_one_idx), 0);
    do_start(32'h805C_9BD2, 5'd4, 5'd4);
    wait_done(cyc);
    chk("one4_ones", 32'(ones_count), 1);
    chk("one4_first", 32'(first_one_idx), 4);
    step(1);

    // Backpressure with ready pattern 1,0,0,1.
    do_start(32'hFFFF_FFFF, 5'd0, 5'd7);
    stalls = 0;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
      bit_ready = pat[i % 4][0];
      if (bit_valid && !bit_ready) stalls++;
    end
    bit_ready = 1;
    chk("bp_stalled", 32'(stalls > 0), 1);
    chk("bp_latency", cyc, 9 + stalls);
    chk("bp_ones", 32'(ones_count), 8);
    step(1);

    // Start while busy is ignored; abort at scan cycle 10.
    do_start(32'h1234_5678, 5'd0, 5'd31);
    step(2);
    start = 1; data_in = 32'hDEAD_BEEF; first_sel = 5'd7; last_sel = 5'd2;
    step(1);
    start = 0;
    step(6);
    abort = 1;
    step(1);
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(bit_valid), 0);
    chk("abort_ones", 32'(ones_count), 0);
    chk("abort_found", 32'(found), 0);
    chk("abort_src", mux_source, 32'h1234_5678);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step(1);
    end
    chk("abort_no_done", ndone, 0);

    // Reset mid-scan.
    do_start(32'h805C_9BD2, 5'd0, 5'd31);
    step(4);
    reset = 1;
    step(1);
    reset = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(bit_valid), 0);
    chk("rst_src", mux_source, 0);
    chk("rst_sel", 32'(mux_select), 0);
    chk("rst_ones", 32'(ones_count), 0);
    step(1);

    // Back-to-back: new start presented in the done cycle.
    do_start(32'hA5A5_A5A5, 5'd2, 5'd4);
    wait_done(cyc);
    chk("b2b_latency", cyc, 4);
    chk("b2b_ones", 32'(ones_count), 1);
    chk("b2b_first", 32'(first_one_idx), 2);
    do_start(32'h0F0F_0F0F, 5'd10, 5'd8);
    chk("b2b_restart_busy", 32'(busy), 1);
    wait_done(cyc);
    chk("b2b2_latency", cyc, 4);
    chk("b2b2_ones", 32'(ones_count), 3);
    chk("b2b2_first", 32'(first_one_idx), 10);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
